// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared defaults and stage-count helper for pipe_adder.
// Optional feature macro used by this block: PIPE_ADDER_OVF_EN.
package pipe_adder_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    function automatic int stages_of(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result handshake bundle for pipe_adder.
// ovf exists only when PIPE_ADDER_OVF_EN is defined.
interface pipe_adder_if
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
`ifdef PIPE_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, s, c_out
`ifdef PIPE_ADDER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, s, c_out
`ifdef PIPE_ADDER_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/pipe_adder_rca_chunk.sv
// rca_chunk: combinational CHUNK-bit ripple-carry adder from full adders.
// One instance sits in each pipe_adder stage.
module rca_chunk
    import pipe_adder_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] s,
    output logic             c_out
);

    logic [CHUNK:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[CHUNK];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: skewed carry-pipelined adder, one CHUNK-bit ripple per stage.
// Define PIPE_ADDER_OVF_EN to add the signed-overflow output ovf.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic        clk,
    input  logic        rst_n,
    pipe_adder_if.slave bus
);

    localparam int STAGES = stages_of(WIDTH, CHUNK);

    if ((WIDTH % CHUNK) != 0 || STAGES < 1) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a positive multiple of CHUNK");
    end

    logic adv;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * CHUNK;
        localparam int HI = LO + CHUNK;

        // Unconsumed operand bits arriving at this stage
        logic [WIDTH-1:LO] a_src;
        logic [WIDTH-1:LO] b_src;
        logic              c_src;
        logic              v_src;
        logic [CHUNK-1:0]  cs;
        logic              co;
        logic [HI-1:0]     s_d;
        logic [HI-1:0]     s_q;
        logic              c_q;
        logic              v_q;
`ifdef PIPE_ADDER_OVF_EN
        logic              sa_src;
        logic              sb_src;
`endif

        if (k == 0) begin : g_in
            assign a_src = bus.a;
            assign b_src = bus.b;
            assign c_src = bus.c_in;
            assign v_src = bus.in_valid;
            assign s_d   = cs;
`ifdef PIPE_ADDER_OVF_EN
            assign sa_src = bus.a[WIDTH-1];
            assign sb_src = bus.b[WIDTH-1];
`endif
        end else begin : g_in
            assign a_src = g_stg[k-1].g_op.a_q;
            assign b_src = g_stg[k-1].g_op.b_q;
            assign c_src = g_stg[k-1].c_q;
            assign v_src = g_stg[k-1].v_q;
            assign s_d   = {cs, g_stg[k-1].s_q};
`ifdef PIPE_ADDER_OVF_EN
            assign sa_src = g_stg[k-1].g_op.sa_q;
            assign sb_src = g_stg[k-1].g_op.sb_q;
`endif
        end

        rca_chunk #(
            .CHUNK (CHUNK)
        ) u_rca (
            .a     (a_src[HI-1:LO]),
            .b     (b_src[HI-1:LO]),
            .c_in  (c_src),
            .s     (cs),
            .c_out (co)
        );

        // Register valid, completed sum chunks and carry; freeze on stall
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                s_q <= '0;
                c_q <= 1'b0;
            end else if (adv) begin
                v_q <= v_src;
                s_q <= s_d;
                c_q <= co;
            end
        end

        if (k < STAGES - 1) begin : g_op
            logic [WIDTH-1:HI] a_q;
            logic [WIDTH-1:HI] b_q;
`ifdef PIPE_ADDER_OVF_EN
            logic              sa_q;
            logic              sb_q;

            // Carry operand sign bits toward the overflow stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sa_q <= 1'b0;
                    sb_q <= 1'b0;
                end else if (adv) begin
                    sa_q <= sa_src;
                    sb_q <= sb_src;
                end
            end
`endif

            // Pass the not-yet-added operand chunks down the skew
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_src[WIDTH-1:HI];
                    b_q <= b_src[WIDTH-1:HI];
                end
            end
        end

`ifdef PIPE_ADDER_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            // Signed overflow registered alongside the final sum chunk
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= (sa_src == sb_src) && (cs[CHUNK-1] != sa_src);
                end
            end
        end
`endif
    end

    assign bus.out_valid = g_stg[STAGES-1].v_q;
    assign bus.s         = g_stg[STAGES-1].s_q;
    assign bus.c_out     = g_stg[STAGES-1].c_q;
`ifdef PIPE_ADDER_OVF_EN
    assign bus.ovf       = g_stg[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: randomized + directed bench for pipe_adder (32/8, 4 stages).
// Honours PIPE_ADDER_OVF_EN the same way as the design.
module tb_pipe_adder;

    localparam int W  = 32;
    localparam int NS = 4;

    typedef struct {
        bit          v;
        logic [W-1:0] s;
        bit          c;
        bit          o;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(W)) bus_if();

    pipe_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    res_t pipe [NS];

    logic [W-1:0] out_s_q [$];
    bit           out_c_q [$];
    bit           out_o_q [$];
    int           out_cyc_q [$];
    int           acc_cyc_q [$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic res_t ref_add(input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     input logic ci);
        res_t r;
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        r.v = 1'b1;
        r.s = full[W-1:0];
        r.c = full[W];
        r.o = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return r;
    endfunction

    function automatic bit model_busy();
        bit busy = 1'b0;
        for (int i = 0; i < NS; i++) busy |= pipe[i].v;
        return busy;
    endfunction

    always @(posedge clk) cyc++;

    // Reference pipeline: NS slots that shift whenever the output is free
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) pipe[i].v = 1'b0;
        end else begin
            bit adv;
            adv = !pipe[NS-1].v || bus_if.out_ready;
            chk("in_ready", {63'd0, bus_if.in_ready}, {63'd0, adv});
            chk("out_valid", {63'd0, bus_if.out_valid}, {63'd0, pipe[NS-1].v});
            if (pipe[NS-1].v) begin
                chk("s", {32'd0, bus_if.s}, {32'd0, pipe[NS-1].s});
                chk("c_out", {63'd0, bus_if.c_out}, {63'd0, pipe[NS-1].c});
`ifdef PIPE_ADDER_OVF_EN
                chk("ovf", {63'd0, bus_if.ovf}, {63'd0, pipe[NS-1].o});
`endif
                if (bus_if.out_ready) begin
                    out_s_q.push_back(bus_if.s);
                    out_c_q.push_back(bus_if.c_out);
`ifdef PIPE_ADDER_OVF_EN
                    out_o_q.push_back(bus_if.ovf);
`else
                    out_o_q.push_back(1'b0);
`endif
                    out_cyc_q.push_back(cyc);
                end
            end
            if (adv) begin
                for (int i = NS - 1; i > 0; i--) pipe[i] = pipe[i-1];
                if (bus_if.in_valid)
                    pipe[0] = ref_add(bus_if.a, bus_if.b, bus_if.c_in);
                else
                    pipe[0].v = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        out_s_q.delete();
        out_c_q.delete();
        out_o_q.delete();
        out_cyc_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci);
        int  t    = 0;
        bit  done = 1'b0;
        bus_if.in_valid = 1'b1;
        bus_if.a        = a;
        bus_if.b        = b;
        bus_if.c_in     = ci;
        while (!done) begin
            @(negedge clk);
            if (bus_if.in_ready) begin
                done = 1'b1;
                acc_cyc_q.push_back(cyc);
            end
            step();
            t++;
            if (!done && t > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stuck low");
                done = 1'b1;
            end
        end
        bus_if.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        bus_if.out_ready = 1'b1;
        while (model_busy() && t < 40) begin
            step();
            t++;
        end
        step();
        if (model_busy()) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: results still pending");
        end
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held;
        int           n_before;
        bit           acc;

        bus_if.in_valid  = 1'b0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        bus_if.c_in      = 1'b0;
        bus_if.out_ready = 1'b1;
        rst_n            = 1'b0;

        step();
        chk("rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
        chk("rst_s", {32'd0, bus_if.s}, 64'd0);
        chk("rst_c_out", {63'd0, bus_if.c_out}, 64'd0);
`ifdef PIPE_ADDER_OVF_EN
        chk("rst_ovf", {63'd0, bus_if.ovf}, 64'd0);
`endif
        step();
        rst_n = 1'b1;
        step();

        // All-ones plus carry-in ripples through every chunk
        clear_logs();
        send(32'hFFFF_FFFF, 32'h0, 1'b1);
        drain();
        chk("ones_count", 64'(out_s_q.size()), 64'd1);
        if (out_s_q.size() == 1) begin
            chk("ones_s", {32'd0, out_s_q[0]}, 64'd0);
            chk("ones_c", {63'd0, out_c_q[0]}, 64'd1);
            chk("ones_lat", 64'(out_cyc_q[0] - acc_cyc_q[0]), 64'd4);
`ifdef PIPE_ADDER_OVF_EN
            chk("ones_ovf", {63'd0, out_o_q[0]}, 64'd0);
`endif
        end

        // Signed overflow corners
        clear_logs();
        send(32'h7FFF_FFFF, 32'h1, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0);
        drain();
        chk("ovf_count", 64'(out_s_q.size()), 64'd2);
        if (out_s_q.size() == 2) begin
            chk("pos_ovf_s", {32'd0, out_s_q[0]}, 64'h8000_0000);
            chk("pos_ovf_c", {63'd0, out_c_q[0]}, 64'd0);
            chk("neg_ovf_s", {32'd0, out_s_q[1]}, 64'd0);
            chk("neg_ovf_c", {63'd0, out_c_q[1]}, 64'd1);
`ifdef PIPE_ADDER_OVF_EN
            chk("pos_ovf_o", {63'd0, out_o_q[0]}, 64'd1);
            chk("neg_ovf_o", {63'd0, out_o_q[1]}, 64'd1);
`endif
        end

        // Eight back-to-back transfers, no stall
        clear_logs();
        for (int i = 0; i < 8; i++) send(W'(i * 1000), W'(i * 7), i[0]);
        drain();
        chk("b2b_count", 64'(out_s_q.size()), 64'd8);
        if (out_s_q.size() == 8) begin
            chk("b2b_lat", 64'(out_cyc_q[0] - acc_cyc_q[0]), 64'd4);
            chk("b2b_span", 64'(out_cyc_q[7] - out_cyc_q[0]), 64'd7);
            chk("b2b_s3", {32'd0, out_s_q[3]}, 64'd3022);
            chk("b2b_s7", {32'd0, out_s_q[7]}, 64'd7050);
            for (int i = 0; i < 8; i++)
                chk("b2b_order", {32'd0, out_s_q[i]},
                    64'(i * 1000 + i * 7 + (i % 2)));
        end

        // Same stream with a three-cycle downstream stall
        clear_logs();
        fork
            begin
                for (int i = 0; i < 8; i++) send(W'(i * 1000), W'(i * 7), i[0]);
            end
            begin
                int t = 0;
                while (out_s_q.size() < 2 && t < 40) begin
                    step();
                    t++;
                end
                bus_if.out_ready = 1'b0;
                step();
                held = bus_if.s;
                step();
                step();
                chk("stall_valid", {63'd0, bus_if.out_valid}, 64'd1);
                chk("stall_ready", {63'd0, bus_if.in_ready}, 64'd0);
                chk("stall_hold", {32'd0, bus_if.s}, {32'd0, held});
                bus_if.out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_count", 64'(out_s_q.size()), 64'd8);
        if (out_s_q.size() == 8)
            for (int i = 0; i < 8; i++)
                chk("stall_order", {32'd0, out_s_q[i]},
                    64'(i * 1000 + i * 7 + (i % 2)));

        // Reset with results in flight
        clear_logs();
        for (int i = 0; i < 4; i++) send(W'(i + 5), W'(i * 3), 1'b0);
        chk("pre_rst_valid", {63'd0, bus_if.out_valid}, 64'd1);
        n_before = out_s_q.size();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, bus_if.out_valid}, 64'd0);
        chk("mid_rst_s", {32'd0, bus_if.s}, 64'd0);
        chk("mid_rst_c", {63'd0, bus_if.c_out}, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {63'd0, bus_if.in_ready}, 64'd1);
        for (int i = 0; i < 10; i++) step();
        chk("no_stale", 64'(out_s_q.size()), 64'(n_before));

        // Randomized traffic with random backpressure
        clear_logs();
        acc = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!bus_if.in_valid || acc) begin
                bus_if.in_valid = ($urandom_range(0, 1) == 1);
                bus_if.a        = rnd_op();
                bus_if.b        = rnd_op();
                bus_if.c_in     = $urandom_range(0, 1) == 1;
            end
            bus_if.out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            acc = bus_if.in_valid && bus_if.in_ready;
            if (acc) acc_cyc_q.push_back(cyc);
            step();
        end
        bus_if.in_valid = 1'b0;
        drain();
        chk("rand_count", 64'(out_s_q.size()), 64'(acc_cyc_q.size()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
